// File: rtl/decomp_stream_router_pkg.sv
// Shared types for the decompression stream router: FSM state encoding,
// per-packet mode encodings and the mode-to-state mapping used at packet start.
package decomp_stream_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BYP  = 2'd1,
        ST_ENG  = 2'd2
    } state_e;

    localparam logic MODE_BYP = 1'b0;
    localparam logic MODE_ENG = 1'b1;

    // Path state entered when a packet with the given mode starts.
    function automatic state_e mode_to_state(input logic mode);
        if (mode == MODE_ENG) begin
            return ST_ENG;
        end else begin
            return ST_BYP;
        end
    endfunction

endpackage

// File: rtl/decomp_stream_router_axis_reg_slice.sv
// Full-throughput AXI-stream register slice. Accepts a beat whenever it is
// empty or its downstream takes the held beat in the same cycle, and keeps the
// payload frozen while stalled.
module axis_reg_slice
    import decomp_stream_router_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_data,
    input  logic [KEEP_W-1:0] s_keep,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic [KEEP_W-1:0] keep_r;
    logic              last_r;

    assign s_ready = !valid_r || m_ready;
    assign m_valid = valid_r;
    assign m_data  = data_r;
    assign m_keep  = keep_r;
    assign m_last  = last_r;

    // Occupancy: refill (or empty) only when the held beat can move on.
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_r <= 1'b0;
        end else if (s_ready) begin
            valid_r <= s_valid;
        end
    end

    // Payload: captured only on an accepted beat, so it holds during stalls.
    always_ff @(posedge aclk) begin
        if (s_valid && s_ready) begin
            data_r <= s_data;
            keep_r <= s_keep;
            last_r <= s_last;
        end
    end

endmodule

// File: rtl/decomp_stream_router.sv
// Routes one packet at a time from the input FIFO either through a bypass
// register pipeline or through the external decompress engine, and counts
// completed packets per path.
module decomp_stream_router
    import decomp_stream_router_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int BYP_STAGES = 1,
    parameter int CNT_W      = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    input  logic              s_mode,
    output logic              s_tready,
    output logic [DATA_W-1:0] eo_tdata,
    output logic [KEEP_W-1:0] eo_tkeep,
    output logic              eo_tlast,
    output logic              eo_tvalid,
    input  logic              eo_tready,
    input  logic [DATA_W-1:0] ei_tdata,
    input  logic [KEEP_W-1:0] ei_tkeep,
    input  logic              ei_tlast,
    input  logic              ei_tvalid,
    output logic              ei_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [CNT_W-1:0]  pkt_byp_cnt,
    output logic [CNT_W-1:0]  pkt_eng_cnt
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              mode_r;
    logic              in_done_r;
    logic [CNT_W-1:0]  byp_cnt_r;
    logic [CNT_W-1:0]  eng_cnt_r;

    logic              byp_in_valid_s;
    logic              byp_in_ready_s;
    logic [DATA_W-1:0] byp_data_s;
    logic [KEEP_W-1:0] byp_keep_s;
    logic              byp_last_s;
    logic              byp_valid_s;
    logic              byp_out_ready_s;
    logic              in_last_hs_s;
    logic              out_last_hs_s;

    // Bypass pipeline: stage 0 takes s_*, the last stage feeds m_*.
    for (genvar i = 0; i < BYP_STAGES; i++) begin : g_stage
        logic [DATA_W-1:0] in_data_s;
        logic [KEEP_W-1:0] in_keep_s;
        logic              in_last_s;
        logic              in_valid_s;
        logic              in_ready_s;
        logic [DATA_W-1:0] out_data_s;
        logic [KEEP_W-1:0] out_keep_s;
        logic              out_last_s;
        logic              out_valid_s;
        logic              out_ready_s;

        if (i == 0) begin : g_head
            assign in_data_s  = s_tdata;
            assign in_keep_s  = s_tkeep;
            assign in_last_s  = s_tlast;
            assign in_valid_s = byp_in_valid_s;
        end else begin : g_link
            assign in_data_s  = g_stage[i-1].out_data_s;
            assign in_keep_s  = g_stage[i-1].out_keep_s;
            assign in_last_s  = g_stage[i-1].out_last_s;
            assign in_valid_s = g_stage[i-1].out_valid_s;
        end

        if (i == BYP_STAGES - 1) begin : g_tail
            assign out_ready_s = byp_out_ready_s;
        end else begin : g_mid
            assign out_ready_s = g_stage[i+1].in_ready_s;
        end

        axis_reg_slice #(
            .DATA_W (DATA_W),
            .KEEP_W (KEEP_W)
        ) u_slice (
            .aclk    (aclk),
            .areset  (areset),
            .s_data  (in_data_s),
            .s_keep  (in_keep_s),
            .s_last  (in_last_s),
            .s_valid (in_valid_s),
            .s_ready (in_ready_s),
            .m_data  (out_data_s),
            .m_keep  (out_keep_s),
            .m_last  (out_last_s),
            .m_valid (out_valid_s),
            .m_ready (out_ready_s)
        );
    end

    assign byp_in_ready_s = g_stage[0].in_ready_s;
    assign byp_data_s     = g_stage[BYP_STAGES-1].out_data_s;
    assign byp_keep_s     = g_stage[BYP_STAGES-1].out_keep_s;
    assign byp_last_s     = g_stage[BYP_STAGES-1].out_last_s;
    assign byp_valid_s    = g_stage[BYP_STAGES-1].out_valid_s;

    assign in_last_hs_s  = s_tvalid && s_tready && s_tlast;
    assign out_last_hs_s = m_tvalid && m_tready && m_tlast;
    assign pkt_byp_cnt   = byp_cnt_r;
    assign pkt_eng_cnt   = eng_cnt_r;

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: pick a path when a packet waits, return once its last beat leaves.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (s_tvalid) begin
                    state_nxt_s = mode_to_state(s_mode);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BYP, ST_ENG: begin
                if (out_last_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bypass pipeline controls; slices only see traffic while in BYP.
    always_comb begin
        byp_in_valid_s  = 1'b0;
        byp_out_ready_s = 1'b0;
        if (!areset && (state_r == ST_BYP)) begin
            byp_in_valid_s  = s_tvalid && !in_done_r;
            byp_out_ready_s = m_tready;
        end else begin
            byp_in_valid_s  = 1'b0;
            byp_out_ready_s = 1'b0;
        end
    end

    // Port routing per state; everything is held off while reset is high.
    always_comb begin
        s_tready  = 1'b0;
        eo_tdata  = s_tdata;
        eo_tkeep  = s_tkeep;
        eo_tlast  = s_tlast;
        eo_tvalid = 1'b0;
        ei_tready = 1'b0;
        m_tdata   = byp_data_s;
        m_tkeep   = byp_keep_s;
        m_tlast   = byp_last_s;
        m_tvalid  = 1'b0;
        if (!areset) begin
            case (state_r)
                ST_BYP: begin
                    s_tready = byp_in_ready_s && !in_done_r;
                    m_tvalid = byp_valid_s;
                end
                ST_ENG: begin
                    eo_tvalid = s_tvalid && !in_done_r;
                    s_tready  = eo_tready && !in_done_r;
                    m_tdata   = ei_tdata;
                    m_tkeep   = ei_tkeep;
                    m_tlast   = ei_tlast;
                    m_tvalid  = ei_tvalid;
                    ei_tready = m_tready;
                end
                default: begin
                    s_tready = 1'b0;
                end
            endcase
        end else begin
            s_tready = 1'b0;
        end
    end

    // Packet mode latch and input-done flag that closes the input after its tlast.
    always_ff @(posedge aclk) begin
        if (areset) begin
            mode_r    <= MODE_BYP;
            in_done_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && s_tvalid) begin
                mode_r <= s_mode;
            end
            if (out_last_hs_s) begin
                in_done_r <= 1'b0;
            end else if (in_last_hs_s) begin
                in_done_r <= 1'b1;
            end
        end
    end

    // Completed-packet counters, bumped on the output tlast handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            byp_cnt_r <= {CNT_W{1'b0}};
            eng_cnt_r <= {CNT_W{1'b0}};
        end else if (out_last_hs_s) begin
            if (mode_r == MODE_ENG) begin
                eng_cnt_r <= eng_cnt_r + CNT_W'(1);
            end else begin
                byp_cnt_r <= byp_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_decomp_stream_router.sv
// Scoreboard bench for decomp_stream_router: drives packets on s_*, models the
// decompress engine (inverting echo, 5-cycle delay) and checks m_* in order.
module tb_decomp_stream_router;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int BS = 2;
    localparam int CW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast, s_tvalid, s_mode, s_tready;
    logic [DW-1:0] eo_tdata;
    logic [KW-1:0] eo_tkeep;
    logic          eo_tlast, eo_tvalid, eo_tready;
    logic [DW-1:0] ei_tdata;
    logic [KW-1:0] ei_tkeep;
    logic          ei_tlast, ei_tvalid, ei_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast, m_tvalid, m_tready;
    logic [CW-1:0] pkt_byp_cnt, pkt_eng_cnt;

    decomp_stream_router #(
        .DATA_W(DW), .KEEP_W(KW), .BYP_STAGES(BS), .CNT_W(CW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
        .s_mode(s_mode), .s_tready(s_tready),
        .eo_tdata(eo_tdata), .eo_tkeep(eo_tkeep), .eo_tlast(eo_tlast), .eo_tvalid(eo_tvalid),
        .eo_tready(eo_tready),
        .ei_tdata(ei_tdata), .ei_tkeep(ei_tkeep), .ei_tlast(ei_tlast), .ei_tvalid(ei_tvalid),
        .ei_tready(ei_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .pkt_byp_cnt(pkt_byp_cnt), .pkt_eng_cnt(pkt_eng_cnt)
    );

    always #5 aclk = ~aclk;

    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    exp_byp = 0;
    int    exp_eng = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t eo_obs_q[$];
    beat_t eng_q[$];
    int    eng_rdy_q[$];
    int    obs_cyc_q[$];
    int    acc_cyc_q[$];
    int    stall_err = 0;
    int    rdy_err = 0;
    int    ei_rdy_seen = 0;
    logic  hold_pend = 1'b0;
    logic  in_done_tb = 1'b0;
    beat_t hold_val;
    bit    stall_pat_en = 1'b0;
    bit    pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always @(posedge aclk) cyc <= cyc + 1;

    // Monitor: record handshakes, stall stability and input-closed behaviour.
    always @(negedge aclk) begin
        if (m_tvalid && m_tready) begin
            obs_q.push_back(beat_t'{m_tdata, m_tkeep, m_tlast});
            obs_cyc_q.push_back(cyc);
        end
        if (s_tvalid && s_tready) acc_cyc_q.push_back(cyc);
        if (ei_tready) ei_rdy_seen <= ei_rdy_seen + 1;
        if (areset) begin
            hold_pend  <= 1'b0;
            in_done_tb <= 1'b0;
        end else begin
            if (hold_pend && (!m_tvalid || (beat_t'{m_tdata, m_tkeep, m_tlast} !== hold_val)))
                stall_err <= stall_err + 1;
            hold_pend <= m_tvalid && !m_tready;
            hold_val  <= beat_t'{m_tdata, m_tkeep, m_tlast};
            if (in_done_tb && (s_tready || eo_tvalid)) rdy_err <= rdy_err + 1;
            if (m_tvalid && m_tready && m_tlast) in_done_tb <= 1'b0;
            else if (s_tvalid && s_tready && s_tlast) in_done_tb <= 1'b1;
        end
    end

    // Engine model: accepts every eo beat, returns it inverted 5 cycles later.
    initial begin : engine_model
        bit    hs;
        beat_t b;
        eo_tready = 1'b1;
        ei_tvalid = 1'b0;
        ei_tdata  = '0;
        ei_tkeep  = '0;
        ei_tlast  = 1'b0;
        forever begin
            @(negedge aclk);
            if (eo_tvalid && eo_tready) begin
                eo_obs_q.push_back(beat_t'{eo_tdata, eo_tkeep, eo_tlast});
                eng_q.push_back(beat_t'{~eo_tdata, eo_tkeep, eo_tlast});
                eng_rdy_q.push_back(cyc + 5);
            end
            hs = ei_tvalid && ei_tready;
            @(posedge aclk); #1;
            if (hs) ei_tvalid = 1'b0;
            if (!ei_tvalid && (eng_q.size() > 0) && (cyc >= eng_rdy_q[0])) begin
                b = eng_q.pop_front();
                void'(eng_rdy_q.pop_front());
                ei_tdata  = b.d;
                ei_tkeep  = b.k;
                ei_tlast  = b.l;
                ei_tvalid = 1'b1;
            end
        end
    end

    // Output sink: m_tready always 1, or the 1,0,0,1,0,1 stall pattern.
    initial begin : sink
        int idx;
        idx = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            if (stall_pat_en) begin
                m_tready = pat[idx % 6];
                idx++;
            end else begin
                m_tready = 1'b1;
                idx = 0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish within 30000 cycles");
        $fatal(1);
    end

    task automatic send_pkt(input logic mode, input int n, input logic [DW-1:0] base);
        beat_t b;
        int    t;
        for (int i = 0; i < n; i++) begin
            b.d = base + DW'(i);
            b.k = KW'(i * 5 + 3);
            b.l = (i == n - 1);
            s_tdata  = b.d;
            s_tkeep  = b.k;
            s_tlast  = b.l;
            s_mode   = mode;
            s_tvalid = 1'b1;
            if (mode) b.d = ~b.d;
            exp_q.push_back(b);
            t = 0;
            do begin
                @(negedge aclk);
                t++;
            end while (!s_tready && t < 200);
            if (!s_tready) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout beat=%0d s_tready=0 required 1 within 200 cycles", i);
            end
            @(posedge aclk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int t;
        t = 0;
        while ((obs_q.size() < exp_q.size()) && (t < 500)) begin
            @(negedge aclk);
            t++;
        end
        ok = (obs_q.size() >= exp_q.size());
        repeat (8) @(negedge aclk);
    endtask

    task automatic test_reset();
        areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_mode = 1'b0;
        s_tdata = '0; s_tkeep = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_tests++;
        if ({s_tready, m_tvalid, eo_tvalid, ei_tready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_during ready/valid=%b required 0000", {s_tready, m_tvalid, eo_tvalid, ei_tready});
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        n_tests++;
        if ({s_tready, m_tvalid, eo_tvalid, ei_tready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_after ready/valid=%b required 0000", {s_tready, m_tvalid, eo_tvalid, ei_tready});
        end
        n_tests++;
        if ((pkt_byp_cnt !== CW'(0)) || (pkt_eng_cnt !== CW'(0))) begin
            n_fail++;
            $display("FAIL rst_cnt byp=%0d eng=%0d required 0 0", pkt_byp_cnt, pkt_eng_cnt);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_bypass();
        bit    ok;
        beat_t e, o;
        acc_cyc_q.delete(); obs_cyc_q.delete();
        send_pkt(1'b0, 4, 32'hA000_0010);
        wait_drain(ok);
        exp_byp++;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ((i >= acc_cyc_q.size()) || (i >= obs_cyc_q.size()) || (obs_cyc_q[i] - acc_cyc_q[i] != BS)) begin
                n_fail++;
                $display("FAIL byp_latency beat=%0d got %0d required %0d", i,
                         ((i < acc_cyc_q.size()) && (i < obs_cyc_q.size())) ? obs_cyc_q[i] - acc_cyc_q[i] : -1, BS);
            end
        end
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL byp_beats got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL byp_beat got %h/%h/%b required %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if (pkt_byp_cnt !== CW'(exp_byp)) begin
            n_fail++;
            $display("FAIL byp_cnt got %0d required %0d", pkt_byp_cnt, exp_byp);
        end
    endtask

    task automatic test_bypass_stall();
        bit    ok;
        beat_t e, o;
        int    st0;
        st0 = stall_err;
        stall_pat_en = 1'b1;
        send_pkt(1'b0, 8, 32'hB000_0100);
        wait_drain(ok);
        stall_pat_en = 1'b0;
        exp_byp++;
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_beats got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stall_beat got %h/%h/%b required %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if (stall_err - st0 != 0) begin
            n_fail++;
            $display("FAIL stall_hold unstable stalled cycles=%0d required 0", stall_err - st0);
        end
        n_tests++;
        if (pkt_byp_cnt !== CW'(exp_byp)) begin
            n_fail++;
            $display("FAIL stall_cnt got %0d required %0d", pkt_byp_cnt, exp_byp);
        end
    endtask

    task automatic test_engine();
        bit    ok;
        beat_t e, o;
        int    r0;
        r0 = rdy_err;
        eo_obs_q.delete();
        send_pkt(1'b1, 3, 32'hC000_0200);
        wait_drain(ok);
        exp_eng++;
        n_tests++;
        if (eo_obs_q.size() != 3) begin
            n_fail++;
            $display("FAIL eng_eo_beats got %0d required 3", eo_obs_q.size());
        end
        for (int i = 0; i < 3 && i < eo_obs_q.size(); i++) begin
            n_tests++;
            if (eo_obs_q[i].d !== 32'hC000_0200 + DW'(i)) begin
                n_fail++;
                $display("FAIL eng_eo_data beat=%0d got %h required %h", i, eo_obs_q[i].d, 32'hC000_0200 + DW'(i));
            end
        end
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL eng_beats got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL eng_beat got %h/%h/%b required %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if (rdy_err - r0 != 0) begin
            n_fail++;
            $display("FAIL eng_closed s_tready/eo_tvalid high after input tlast %0d cycles, required 0", rdy_err - r0);
        end
        n_tests++;
        if (pkt_eng_cnt !== CW'(exp_eng)) begin
            n_fail++;
            $display("FAIL eng_cnt got %0d required %0d", pkt_eng_cnt, exp_eng);
        end
    endtask

    task automatic test_back_to_back();
        bit    ok;
        beat_t e, o;
        send_pkt(1'b0, 1, 32'hD000_0300);
        send_pkt(1'b1, 2, 32'hD000_0400);
        send_pkt(1'b0, 2, 32'hD000_0500);
        wait_drain(ok);
        exp_byp += 2;
        exp_eng += 1;
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_beats got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_beat got %h/%h/%b required %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if ((pkt_byp_cnt !== CW'(exp_byp)) || (pkt_eng_cnt !== CW'(exp_eng))) begin
            n_fail++;
            $display("FAIL b2b_cnt got byp=%0d eng=%0d required byp=%0d eng=%0d",
                     pkt_byp_cnt, pkt_eng_cnt, exp_byp, exp_eng);
        end
    endtask

    task automatic test_stray_engine();
        bit    ok;
        beat_t e, o, stray;
        int    r0;
        stray = beat_t'{32'h5EED_0001, 4'hF, 1'b0};
        r0 = ei_rdy_seen;
        eng_q.push_back(stray);
        eng_rdy_q.push_back(0);
        repeat (3) @(posedge aclk);
        #1;
        send_pkt(1'b0, 2, 32'hE000_0600);
        wait_drain(ok);
        exp_byp++;
        n_tests++;
        if (ei_rdy_seen - r0 != 0) begin
            n_fail++;
            $display("FAIL stray_ei_tready high for %0d cycles outside ENG, required 0", ei_rdy_seen - r0);
        end
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stray_byp_beats got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stray_byp_beat got %h/%h/%b required %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l);
            end
        end
        exp_q.delete(); obs_q.delete();
        exp_q.push_back(stray);
        send_pkt(1'b1, 1, 32'hE000_0700);
        wait_drain(ok);
        exp_eng++;
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stray_eng_beats got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stray_eng_beat got %h/%h/%b required %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if ((pkt_byp_cnt !== CW'(exp_byp)) || (pkt_eng_cnt !== CW'(exp_eng))) begin
            n_fail++;
            $display("FAIL stray_cnt got byp=%0d eng=%0d required byp=%0d eng=%0d",
                     pkt_byp_cnt, pkt_eng_cnt, exp_byp, exp_eng);
        end
    endtask

    task automatic test_reset_mid_packet();
        bit    ok;
        beat_t e, o;
        exp_q.delete(); obs_q.delete();
        s_tdata = 32'hF000_0000; s_tkeep = 4'hF; s_tlast = 1'b0; s_mode = 1'b0; s_tvalid = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        n_tests++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_byp_ready got %b required 1", s_tready);
        end
        @(posedge aclk); #1;
        s_tdata = 32'hF000_0001;
        @(posedge aclk); #1;
        s_tdata = 32'hF000_0002;
        areset = 1'b1;
        @(negedge aclk);
        n_tests++;
        if ({s_tready, m_tvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_during s_tready/m_tvalid=%b required 00", {s_tready, m_tvalid});
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        s_tvalid = 1'b0;
        @(negedge aclk);
        n_tests++;
        if ({s_tready, m_tvalid, eo_tvalid, ei_tready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rmid_after ready/valid=%b required 0000", {s_tready, m_tvalid, eo_tvalid, ei_tready});
        end
        exp_byp = 0;
        exp_eng = 0;
        n_tests++;
        if ((pkt_byp_cnt !== CW'(0)) || (pkt_eng_cnt !== CW'(0))) begin
            n_fail++;
            $display("FAIL rmid_cnt got byp=%0d eng=%0d required 0 0", pkt_byp_cnt, pkt_eng_cnt);
        end
        repeat (10) @(negedge aclk);
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL rmid_partial got %0d stray beats on m_* required 0", obs_q.size());
        end
        obs_q.delete();
        @(posedge aclk); #1;
        send_pkt(1'b0, 3, 32'h1234_0800);
        wait_drain(ok);
        exp_byp++;
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rmid_next_beats got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rmid_next_beat got %h/%h/%b required %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_tests++;
        if ((pkt_byp_cnt !== CW'(exp_byp)) || (pkt_eng_cnt !== CW'(exp_eng))) begin
            n_fail++;
            $display("FAIL rmid_next_cnt got byp=%0d eng=%0d required byp=%0d eng=%0d",
                     pkt_byp_cnt, pkt_eng_cnt, exp_byp, exp_eng);
        end
    endtask

    initial begin : main
        test_reset();
        test_bypass();
        test_bypass_stall();
        test_engine();
        test_back_to_back();
        test_stray_engine();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
